// File: rtl/magcomp_hyst_if.sv
// -----------------------------------------------------------------------------
// magcomp_hyst_if
// Bundles the comparator-flag inputs and the debounced-relation outputs of
// magcomp_hyst_monitor so the producer and the monitor share one port.
//
// Parameters
//   CNT_W        width of the change-event counter carried on evt_cnt
//
// Signals (direction seen from the slave / monitor side)
//   in_valid     in   lt/gt/eq valid this cycle
//   lt, gt, eq   in   comparator relation flags
//   clr_cnt      in   synchronous clear of evt_cnt (and sticky err)
//   state_out    out  00 UNKNOWN, 01 BELOW, 10 EQUAL, 11 ABOVE
//   state_known  out  1 when state_out != UNKNOWN
//   change       out  one-cycle pulse on each committed state change
//   err          out  illegal-sample flag
//   evt_cnt      out  saturating count of change pulses
// -----------------------------------------------------------------------------
interface magcomp_hyst_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             lt;
  logic             gt;
  logic             eq;
  logic             clr_cnt;
  logic [1:0]       state_out;
  logic             state_known;
  logic             change;
  logic             err;
  logic [CNT_W-1:0] evt_cnt;

  // Producer side: drives the flags, observes the relation state.
  modport master (
    output in_valid, lt, gt, eq, clr_cnt,
    input  state_out, state_known, change, err, evt_cnt
  );

  // Monitor side.
  modport slave (
    input  in_valid, lt, gt, eq, clr_cnt,
    output state_out, state_known, change, err, evt_cnt
  );
endinterface

// File: rtl/magcomp_hyst_monitor.sv
// -----------------------------------------------------------------------------
// magcomp_hyst_monitor
// Debounces the lt/gt/eq flags of a magnitude comparator into a stable
// relation state (BELOW / EQUAL / ABOVE). A new relation is committed only
// after DEBOUNCE consecutive valid samples of the same class; gaps with
// in_valid=0 do not break a run. Non-one-hot samples are flagged on err and
// committed changes are counted in a saturating counter.
//
// Parameters
//   DEBOUNCE     consecutive matching valid samples to commit (1..255)
//   CNT_W        width of the saturating change-event counter
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   bus          magcomp_hyst_if.slave (flags in, relation state out)
//
// Build option
//   MAGCOMP_HYST_STICKY_ERR_EN
//     defined   : err is sticky from the first illegal sample until clr_cnt
//                 or reset; a new illegal sample in a clr_cnt cycle wins.
//     undefined : err is a one-cycle pulse after each illegal sample and
//                 clr_cnt does not touch it.
// -----------------------------------------------------------------------------
module magcomp_hyst_monitor #(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  magcomp_hyst_if.slave  bus
);

  localparam int RUN_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0] DEB_R   = RUN_W'(DEBOUNCE);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] ST_UNKNOWN = 2'b00;
  localparam logic [1:0] ST_BELOW   = 2'b01;
  localparam logic [1:0] ST_EQUAL   = 2'b10;
  localparam logic [1:0] ST_ABOVE   = 2'b11;

  // Map a flag triple to its relation class; 00 marks an illegal
  // (none-set or multi-set) sample, which can never be a real class.
  function automatic logic [1:0] classify(input logic lt_f, input logic gt_f,
                                          input logic eq_f);
    logic [1:0] cls;
    case ({lt_f, gt_f, eq_f})
      3'b100:  cls = ST_BELOW;
      3'b001:  cls = ST_EQUAL;
      3'b010:  cls = ST_ABOVE;
      default: cls = ST_UNKNOWN;
    endcase
    return cls;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [1:0]       cand_q, cand_d;     // 00 = no candidate
  logic [RUN_W-1:0] run_q, run_d;
  logic             known_q, known_d;
  logic             change_q, change_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       cls_s;
  logic [RUN_W-1:0] run_next_s;
  logic             commit_s;
  logic             illegal_s;

  // State register: synchronous active-low reset, otherwise load next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_UNKNOWN;
      cand_q   <= ST_UNKNOWN;
      run_q    <= '0;
      known_q  <= 1'b0;
      change_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      run_q    <= run_d;
      known_q  <= known_d;
      change_q <= change_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic: classify the sample, advance or restart the run, commit.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    run_d      = run_q;
    run_next_s = run_q;
    commit_s   = 1'b0;
    illegal_s  = 1'b0;
    cls_s      = classify(bus.lt, bus.gt, bus.eq);

    if (bus.in_valid) begin
      if (cls_s == ST_UNKNOWN) begin
        illegal_s = 1'b1;
        cand_d    = ST_UNKNOWN;
        run_d     = '0;
      end else if (cls_s == state_q) begin
        // Sample agrees with the committed relation: abandon any pending run.
        cand_d = ST_UNKNOWN;
        run_d  = '0;
      end else begin
        if (cls_s == cand_q) begin
          run_next_s = run_q + RUN_ONE;
        end else begin
          run_next_s = RUN_ONE;
        end
        // The sample that completes the run commits on the edge capturing it.
        if (run_next_s == DEB_R) begin
          commit_s = 1'b1;
          state_d  = cls_s;
          cand_d   = ST_UNKNOWN;
          run_d    = '0;
        end else begin
          cand_d   = cls_s;
          run_d    = run_next_s;
        end
      end
    end else begin
      // Gap: hold everything, the run survives.
      run_d = run_q;
    end

    known_d  = (state_d != ST_UNKNOWN);
    change_d = commit_s;

    // Clear beats a simultaneous commit; otherwise saturate at all-ones.
    if (bus.clr_cnt) begin
      cnt_d = '0;
    end else if (commit_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

`ifdef MAGCOMP_HYST_STICKY_ERR_EN
    // A fresh illegal sample outranks a clear in the same cycle.
    err_d = illegal_s | (err_q & ~bus.clr_cnt);
`else
    err_d = illegal_s;
`endif
  end

  // Output logic: every output comes straight from a register.
  always_comb begin
    bus.state_out   = state_q;
    bus.state_known = known_q;
    bus.change      = change_q;
    bus.err         = err_q;
    bus.evt_cnt     = cnt_q;
  end

endmodule
